spectro_bank_reader: RTL and testbench
======================================

// Module: spectro_bank_reader
// PURPOSE
//  Downstream stage of the two-bank spectrogram memory writer.
//  - Watches the writer's bank-full / memorization-completed pulses and reads the finished bank back
//    from the shared 512x8 RAM read port.
//  - Streams the words out on a valid/ready byte interface toward the chip output pins.
//  - Reads one bank while the writer fills the other (ping-pong).
// PARAMETERS
//  DATA_W      8    word width of RAM and output stream
//  BANK_DEPTH  200  words in a full bank (addresses 0..BANK_DEPTH-1)
//  ADDR_W      9    RAM address width; MSB = bank select, [ADDR_W-2:0] = index
// PORTS
//  clk                    in   1       clock
//  reset                  in   1       asynchronous, active-high
//  bank0_full             in   1       1-cycle pulse: bank 0 holds BANK_DEPTH valid words
//  bank1_full             in   1       1-cycle pulse: bank 1 holds BANK_DEPTH valid words
//  memorization_completed in   1       1-cycle pulse: capture ended, partial bank ready
//  wr_bank                in   1       writer's current bank bit (addr MSB), sampled with memorization_completed
//  idx_final              in   8       last written index of partial bank
//  rd_addr                out  ADDR_W  RAM read address
//  rd_en                  out  1       RAM read strobe
//  rd_data                in   DATA_W  RAM read data, valid 1 cycle after rd_en
//  out_data               out  DATA_W  stream word
//  out_valid              out  1       out_data valid
//  out_ready              in   1       sink accepts when out_valid&out_ready
//  out_last               out  1       marks final word of a bank transfer
//  out_bank               out  1       bank being streamed
//  frame_done             out  1       1-cycle pulse after last word accepted
//  overrun                out  1       sticky: a bank was re-filled before being drained
// BEHAVIOUR
//  - Reset (async, immediate): all outputs 0, rd_addr=0, pend0=pend1=0, len regs 0, state IDLE.
//  - Request capture, every cycle, registered:
//    - bankN_full -> pendN=1, lenN=BANK_DEPTH.
//    - memorization_completed -> pend[wr_bank]=1, len[wr_bank]=idx_final+1 (9-bit sum; idx_final=199 -> 200).
//    - full on bank b while pend_b=1 or b is being read -> overrun<=1, request dropped.
//    - memorization_completed on bank b already pending/being read -> ignored, no overrun.
//    - bank0_full and bank1_full in the same cycle: both captured.
//  - FSM IDLE/RD/WT/OUT/DONE:
//    - IDLE: if any pend -> select bank, cnt=0, clear pend for it, go RD.
//      Both pending -> bank opposite to last served (bank0 after reset).
//    - RD: rd_en=1, rd_addr={bank,cnt}, go WT.
//    - WT: capture rd_data into out_data, go OUT.
//    - OUT: out_valid=1, out_last=(cnt==len-1); out_data/out_last/out_bank held stable while stalled.
//      On out_valid&out_ready: if last -> DONE, else cnt+=1 -> RD.
//    - DONE: frame_done=1 for one cycle, back to IDLE.
//  - Latency: pulse in cycle t0 -> first out_valid in t4; with out_ready=1, one word per 3 cycles.
//  - rd_en/rd_addr only in RD; rd_addr holds last value otherwise.
//  - len=1 (idx_final=0): single word, out_last on it.
//  - Requests arriving during a transfer queue via pend flags; never disturb the active transfer.
//  - Reset mid-transfer: stream aborts, no frame_done, pend flags lost.
// CONFIGURATION
//  SPECTRO_RD_CKSUM_EN defined:
//    - one extra word after data: XOR of all data words of the bank.
//    - out_last on checksum word, not on last data word.
//    - checksum word issues no RAM read; presented 1 cycle after last data word accepted.
//  Undefined: no checksum; out_last on last data word; no checksum register.
// TESTING
//  1 bank0_full, RAM[a]=a[7:0], out_ready=1 -> 200 words 0..199, out_bank=0, out_last on 199, frame_done once, first valid at t4.
//  2 memorization_completed, wr_bank=1, idx_final=4 -> 5 words from addr 256..260, out_last on 5th, out_bank=1.
//  3 out_ready toggled 1/0 randomly during bank1 transfer -> no words lost/duplicated, outputs stable while stalled.
//  4 bank0_full, then bank1_full during bank0 transfer, then bank0_full again before drain -> both banks streamed, overrun=1.
//  5 reset asserted mid-transfer of word 50 -> outputs 0 same cycle; next bank1_full streams from addr 256.
//  6 SPECTRO_RD_CKSUM_EN, idx_final=2, data 8'h0F,8'hF0,8'h33 -> 4 words, last=8'hCC with out_last.

Source files
------------

// File: rtl/spectro_bank_reader.sv
// Purpose: reads finished spectrogram banks back from the shared 512x8 RAM and streams them out
//          over a valid/ready byte interface, ping-ponging with the writer that fills the other bank.
// Latency/backpressure: a request pulse in cycle t0 gives the first out_valid in t4, then one word
//          every 3 cycles; out_ready low holds out_data/out_last/out_bank until the word is taken.
// Optional feature: define SPECTRO_RD_CKSUM_EN to append an XOR checksum word after each bank's data.
//
// Ports:
//   clk, reset (async, active-high)
//   bank0_full/bank1_full     full-bank request pulses from the writer
//   memorization_completed    partial-bank request pulse; the bank comes from wr_bank, the length is idx_final+1
//   rd_addr/rd_en/rd_data     RAM read port (data valid one cycle after rd_en)
//   out_data/out_valid/out_ready/out_last/out_bank   output byte stream
//   frame_done                one-cycle pulse after the final word of a bank is accepted
//   overrun                   sticky flag: a full bank arrived while that bank was pending or being read
module spectro_bank_reader #(
  parameter int DATA_W     = 8,
  parameter int BANK_DEPTH = 200,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bank0_full,
  input  logic              bank1_full,
  input  logic              memorization_completed,
  input  logic              wr_bank,
  input  logic [ADDR_W-2:0] idx_final,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_bank,
  output logic              frame_done,
  output logic              overrun
);

  localparam int IDX_W = ADDR_W - 1;

  typedef enum logic [2:0] {IDLE, RD, WT, OUT, DONE} state_t;

  state_t            state;
  logic              pend0, pend1;
  logic [ADDR_W-1:0] len0, len1;
  logic [IDX_W-1:0]  cnt;
  logic              last_bank;

`ifdef SPECTRO_RD_CKSUM_EN
  logic [DATA_W-1:0] cksum;
  logic              is_ck;
`endif

  // Next-state values for the request bookkeeping
  logic              p0_nxt, p1_nxt;
  logic [ADDR_W-1:0] l0_nxt, l1_nxt;
  logic              ovr_set;
  logic              busy0, busy1;
  logic              take;
  logic              sel_bank;
  logic [ADDR_W-1:0] full_len, mc_len, cur_len;
  logic              last_data;

  assign full_len  = ADDR_W'(BANK_DEPTH);
  assign mc_len    = ADDR_W'(idx_final) + ADDR_W'(1);
  // out_bank names the bank under transfer whenever the FSM is not idle
  assign busy0     = (state != IDLE) && !out_bank;
  assign busy1     = (state != IDLE) &&  out_bank;
  assign take      = (state == IDLE) && (pend0 || pend1);
  // Both pending: alternate away from the bank served last
  assign sel_bank  = (pend0 && pend1) ? ~last_bank : pend1;
  assign cur_len   = out_bank ? len1 : len0;
  assign last_data = ({1'b0, cnt} == (cur_len - ADDR_W'(1)));

  always_comb begin
    p0_nxt  = pend0;
    p1_nxt  = pend1;
    l0_nxt  = len0;
    l1_nxt  = len1;
    ovr_set = 1'b0;

    if (take && !sel_bank) p0_nxt = 1'b0;
    if (take &&  sel_bank) p1_nxt = 1'b0;

    // A full bank that cannot be queued means the writer lapped the reader
    if (bank0_full) begin
      if (pend0 || busy0) begin
        ovr_set = 1'b1;
      end else begin
        p0_nxt = 1'b1;
        l0_nxt = full_len;
      end
    end
    if (bank1_full) begin
      if (pend1 || busy1) begin
        ovr_set = 1'b1;
      end else begin
        p1_nxt = 1'b1;
        l1_nxt = full_len;
      end
    end

    // A partial-bank notice on a bank already queued or in flight is silently dropped
    if (memorization_completed) begin
      if (!wr_bank) begin
        if (!pend0 && !busy0 && !bank0_full) begin
          p0_nxt = 1'b1;
          l0_nxt = mc_len;
        end
      end else begin
        if (!pend1 && !busy1 && !bank1_full) begin
          p1_nxt = 1'b1;
          l1_nxt = mc_len;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      len0       <= '0;
      len1       <= '0;
      cnt        <= '0;
      last_bank  <= 1'b1;   // makes bank 0 win the first tie
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_bank   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
`ifdef SPECTRO_RD_CKSUM_EN
      cksum      <= '0;
      is_ck      <= 1'b0;
`endif
    end else begin
      pend0 <= p0_nxt;
      pend1 <= p1_nxt;
      len0  <= l0_nxt;
      len1  <= l1_nxt;
      if (ovr_set) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (take) begin
            out_bank  <= sel_bank;
            last_bank <= sel_bank;
            cnt       <= '0;
            rd_en     <= 1'b1;
            rd_addr   <= {sel_bank, IDX_W'(0)};
`ifdef SPECTRO_RD_CKSUM_EN
            cksum     <= '0;
            is_ck     <= 1'b0;
`endif
            state     <= RD;
          end
        end

        RD: begin
          rd_en <= 1'b0;
          state <= WT;
        end

        WT: begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
`ifdef SPECTRO_RD_CKSUM_EN
          cksum     <= cksum ^ rd_data;
          out_last  <= 1'b0;   // the checksum word carries last
`else
          out_last  <= last_data;
`endif
          state     <= OUT;
        end

        OUT: begin
          if (out_ready) begin
`ifdef SPECTRO_RD_CKSUM_EN
            if (is_ck) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else if (last_data) begin
              // cksum already includes the last data word (folded in during WT)
              out_data <= cksum;
              out_last <= 1'b1;
              is_ck    <= 1'b1;
            end else begin
              cnt       <= cnt + IDX_W'(1);
              rd_en     <= 1'b1;
              rd_addr   <= {out_bank, cnt + IDX_W'(1)};
              out_valid <= 1'b0;
              state     <= RD;
            end
`else
            if (out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              cnt       <= cnt + IDX_W'(1);
              rd_en     <= 1'b1;
              rd_addr   <= {out_bank, cnt + IDX_W'(1)};
              out_valid <= 1'b0;
              state     <= RD;
            end
`endif
          end
        end

        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spectro_bank_reader.sv
module tb_spectro_bank_reader;

`ifdef SPECTRO_RD_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       bank0_full, bank1_full, memorization_completed, wr_bank;
  logic [7:0] idx_final;
  logic [8:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last, out_bank, frame_done, overrun;

  always #5 clk = ~clk;

  spectro_bank_reader dut (
    .clk(clk), .reset(reset),
    .bank0_full(bank0_full), .bank1_full(bank1_full),
    .memorization_completed(memorization_completed),
    .wr_bank(wr_bank), .idx_final(idx_final),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_bank(out_bank),
    .frame_done(frame_done), .overrun(overrun)
  );

  // Synchronous-read RAM model
  logic [7:0] mem [512];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_seen = 0;
  int   fd_exp = 0;
  int   popped = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   first_valid_cyc = -1;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink readiness: always ready unless the random-backpressure phase is on
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares accepted words against the scoreboard, checks hold-while-stalled
  logic       stalled_prev = 1'b0;
  logic [7:0] p_d;
  logic       p_l, p_b;
  exp_t       e;
  always @(negedge clk) begin
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (frame_done) fd_seen++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stalled_prev) begin
        checks++;
        if (!out_valid || out_data !== p_d || out_last !== p_l || out_bank !== p_b) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b b=%b, need v=1 d=%h l=%b b=%b",
                   out_valid, out_data, out_last, out_bank, p_d, p_l, p_b);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got d=%h l=%b b=%b, none expected", out_data, out_last, out_bank);
        end else begin
          e = sb.pop_front();
          popped++;
          if (out_data !== e.d || out_last !== e.l || out_bank !== e.b) begin
            errors++;
            $display("FAIL word_%0d: got d=%h l=%b b=%b, need d=%h l=%b b=%b",
                     popped, out_data, out_last, out_bank, e.d, e.l, e.b);
          end
        end
      end
      stalled_prev = out_valid && !out_ready;
      p_d = out_data;
      p_l = out_last;
      p_b = out_bank;
    end
  end

  // Expected stream of a bank: mem contents, last flag, optional XOR word
  task automatic push_bank(input logic b, input int len);
    logic [7:0] x = 8'h00;
    logic [8:0] a;
    for (int i = 0; i < len; i++) begin
      a = {b, 8'(i)};
      x = x ^ mem[a];
      sb.push_back({mem[a], (!CK && i == len - 1), b});
    end
    if (CK) sb.push_back({x, 1'b1, b});
  endtask

  task automatic pulse_full(input logic b);
    @(posedge clk);
    #1;
    if (b) bank1_full = 1'b1; else bank0_full = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    bank0_full = 1'b0;
    bank1_full = 1'b0;
  endtask

  task automatic pulse_mc(input logic b, input logic [7:0] idx);
    @(posedge clk);
    #1;
    memorization_completed = 1'b1;
    wr_bank = b;
    idx_final = idx;
    @(posedge clk);
    #1;
    memorization_completed = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || fd_seen < fd_exp) && n < 6000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (n >= 6000 || sb.size() != 0 || fd_seen != fd_exp) begin
      errors++;
      $display("FAIL %s_done: got left=%0d frame_done=%0d, need left=0 frame_done=%0d",
               name, sb.size(), fd_seen, fd_exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %b, need %b", name, got, need);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (rd_addr !== 9'd0 || rd_en !== 1'b0 || out_data !== 8'd0 || out_valid !== 1'b0 ||
        out_last !== 1'b0 || out_bank !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s: got addr=%h en=%b d=%h v=%b l=%b b=%b fd=%b ov=%b, need all 0", name,
               rd_addr, rd_en, out_data, out_valid, out_last, out_bank, frame_done, overrun);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] a;
    int n;
    for (int i = 0; i < 512; i++) begin
      a = 9'(i);
      mem[i] = a[8] ? ~a[7:0] : a[7:0];
    end
    reset = 1'b1;
    bank0_full = 1'b0;
    bank1_full = 1'b0;
    memorization_completed = 1'b0;
    wr_bank = 1'b0;
    idx_final = 8'd0;
    #1;
    check_reset_outputs("reset_state");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("after_reset_idle");

    // 1: full bank 0, check first-word latency
    first_valid_cyc = -1;
    push_bank(1'b0, 200);
    fd_exp++;
    pulse_full(1'b0);
    wait_done("bank0_full");
    checks++;
    if (first_valid_cyc - t0 != 4) begin
      errors++;
      $display("FAIL latency: got %0d cycles, need 4", first_valid_cyc - t0);
    end

    // 2: partial bank 1, idx_final=4 -> 5 words from 256..260
    sb.push_back({8'hFF, 1'b0, 1'b1});
    sb.push_back({8'hFE, 1'b0, 1'b1});
    sb.push_back({8'hFD, 1'b0, 1'b1});
    sb.push_back({8'hFC, 1'b0, 1'b1});
    sb.push_back({8'hFB, !CK, 1'b1});
    if (CK) sb.push_back({8'hFF ^ 8'hFE ^ 8'hFD ^ 8'hFC ^ 8'hFB, 1'b1, 1'b1});
    fd_exp++;
    pulse_mc(1'b1, 8'd4);
    wait_done("partial_bank1");

    // single-word partial bank
    sb.push_back({8'h00, !CK, 1'b0});
    if (CK) sb.push_back({8'h00, 1'b1, 1'b0});
    fd_exp++;
    pulse_mc(1'b0, 8'd0);
    wait_done("len1");

    // 3: random backpressure on a full bank 1
    rand_rdy = 1'b1;
    push_bank(1'b1, 200);
    fd_exp++;
    pulse_full(1'b1);
    wait_done("backpressure");
    rand_rdy = 1'b0;
    check_bit("overrun_clear", overrun, 1'b0);

`ifdef SPECTRO_RD_CKSUM_EN
    // 6: checksum word 0F^F0^33 = CC
    mem[0] = 8'h0F;
    mem[1] = 8'hF0;
    mem[2] = 8'h33;
    sb.push_back({8'h0F, 1'b0, 1'b0});
    sb.push_back({8'hF0, 1'b0, 1'b0});
    sb.push_back({8'h33, 1'b0, 1'b0});
    sb.push_back({8'hCC, 1'b1, 1'b0});
    fd_exp++;
    pulse_mc(1'b0, 8'd2);
    wait_done("cksum");
    mem[0] = 8'h00;
    mem[1] = 8'h01;
    mem[2] = 8'h02;
`endif

    // 4: ping-pong with a refill of the bank being read
    push_bank(1'b0, 200);
    fd_exp++;
    pulse_full(1'b0);
    repeat (20) @(posedge clk);
    push_bank(1'b1, 200);
    fd_exp++;
    pulse_full(1'b1);
    repeat (20) @(posedge clk);
    pulse_full(1'b0);
    #1;
    check_bit("overrun_set", overrun, 1'b1);
    wait_done("pingpong");
    check_bit("overrun_sticky", overrun, 1'b1);

    // 5: reset in the middle of a transfer
    popped = 0;
    push_bank(1'b0, 200);
    pulse_full(1'b0);
    n = 0;
    while (popped < 50 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL reach_word50: got %0d words, need 50", popped);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("mid_transfer_reset");
    sb.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("no_stale_request");
    push_bank(1'b1, 200);
    fd_exp++;
    pulse_full(1'b1);
    wait_done("post_reset_bank1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
